// File: rtl/tb_ram_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of one single-port RAM.
// Grants are same-cycle; each granted access gets a response exactly one cycle later.
module tb_ram_arbiter #(
  parameter int unsigned RAM_ADDR_WIDTH = 22,
  parameter bit          RR_RESET_PRIO  = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      instr_req_i,
  output logic                      instr_gnt_o,
  input  logic [31:0]               instr_addr_i,
  output logic                      instr_rvalid_o,
  output logic [31:0]               instr_rdata_o,
  output logic                      instr_err_o,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic [31:0]               data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [31:0]               data_rdata_o,
  output logic                      data_err_o,
  output logic                      ram_en_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic                      ram_we_o,
  output logic [3:0]                ram_be_o,
  output logic [31:0]               ram_wdata_o,
  input  logic [31:0]               ram_rdata_i,
  output logic [31:0]               conflict_cnt_o
);

  localparam logic        PORT_INSTR = 1'b0;
  localparam logic        PORT_DATA  = 1'b1;
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

  logic        prio_q, prio_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_port_q, rsp_port_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_read_q, rsp_read_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  logic        both_req_s;
  logic        instr_gnt_s, data_gnt_s, any_gnt_s;
  logic [31:0] sel_addr_s;
  logic        in_range_s;
  logic        ram_en_s, ram_we_s;
  logic        instr_rvalid_s, data_rvalid_s;
  logic        unused_addr_s;

  assign both_req_s = instr_req_i & data_req_i;

  // Grant selection: a lone requester always wins, a conflict is settled by prio_q.
  always_comb begin
    instr_gnt_s = 1'b0;
    data_gnt_s  = 1'b0;
    if (!rst_ni) begin
      instr_gnt_s = 1'b0;
      data_gnt_s  = 1'b0;
    end else if (both_req_s) begin
      if (prio_q == PORT_DATA) begin
        data_gnt_s = 1'b1;
      end else begin
        instr_gnt_s = 1'b1;
      end
    end else if (instr_req_i) begin
      instr_gnt_s = 1'b1;
    end else if (data_req_i) begin
      data_gnt_s = 1'b1;
    end else begin
      instr_gnt_s = 1'b0;
      data_gnt_s  = 1'b0;
    end
  end

  assign any_gnt_s  = instr_gnt_s | data_gnt_s;
  assign sel_addr_s = data_gnt_s ? data_addr_i : instr_addr_i;
  assign in_range_s = (sel_addr_s >> RAM_ADDR_WIDTH) == 32'd0;
  // Out-of-range accesses are still granted but never reach the RAM.
  assign ram_en_s   = any_gnt_s & in_range_s;
  assign ram_we_s   = ram_en_s & data_gnt_s & data_we_i;

  assign unused_addr_s = ^sel_addr_s[1:0];

  assign instr_gnt_o = instr_gnt_s;
  assign data_gnt_o  = data_gnt_s;
  assign ram_en_o    = ram_en_s;
  assign ram_we_o    = ram_we_s;
  assign ram_addr_o  = {sel_addr_s[RAM_ADDR_WIDTH-1:2], 2'b00};
  assign ram_be_o    = data_gnt_s ? data_be_i : 4'hF;
  assign ram_wdata_o = data_wdata_i;

  // Next-state: priority rotation, pending response bookkeeping, conflict counter.
  always_comb begin
    prio_d         = prio_q;
    rsp_valid_d    = any_gnt_s;
    rsp_port_d     = data_gnt_s ? PORT_DATA : PORT_INSTR;
    rsp_err_d      = any_gnt_s & ~in_range_s;
    rsp_read_d     = ram_en_s & ~ram_we_s;
    conflict_cnt_d = conflict_cnt_q;
    if (instr_gnt_s) begin
      prio_d = PORT_DATA;
    end else if (data_gnt_s) begin
      prio_d = PORT_INSTR;
    end else begin
      prio_d = prio_q;
    end
    if (both_req_s && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // State registers; reset also discards any response still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q         <= RR_RESET_PRIO;
      rsp_valid_q    <= 1'b0;
      rsp_port_q     <= PORT_INSTR;
      rsp_err_q      <= 1'b0;
      rsp_read_q     <= 1'b0;
      conflict_cnt_q <= 32'd0;
    end else begin
      prio_q         <= prio_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_port_q     <= rsp_port_d;
      rsp_err_q      <= rsp_err_d;
      rsp_read_q     <= rsp_read_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign instr_rvalid_s = rsp_valid_q & (rsp_port_q == PORT_INSTR);
  assign data_rvalid_s  = rsp_valid_q & (rsp_port_q == PORT_DATA);

  assign instr_rvalid_o = instr_rvalid_s;
  assign data_rvalid_o  = data_rvalid_s;
  // Read data only passes through for in-range reads; everything else returns zero.
  assign instr_rdata_o  = (instr_rvalid_s & rsp_read_q) ? ram_rdata_i : 32'd0;
  assign data_rdata_o   = (data_rvalid_s & rsp_read_q) ? ram_rdata_i : 32'd0;
  assign instr_err_o    = instr_rvalid_s & rsp_err_q;
  assign data_err_o     = data_rvalid_s & rsp_err_q;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_tb_ram_arbiter.sv
// Randomized bench for tb_ram_arbiter: a transaction-level model predicts grants,
// RAM strobes, responses and the conflict counter from the arbitration rules.
module tb_tb_ram_arbiter;

  localparam int unsigned AW       = 22;
  localparam bit          RST_PRIO = 1'b0;

  logic          clk, rst_n;
  logic          ireq, dreq, dwe;
  logic [31:0]   iaddr, daddr, dwdata;
  logic [3:0]    dbe;
  logic          igc, dgc, irv, drv, ierr, derr;
  logic [31:0]   ird, drd;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata, ram_rdata, cnt;

  int total, bad;

  // Reference model state
  logic        m_prio;
  logic        m_pv, m_pp, m_perr;
  logic [31:0] m_prd;
  logic [31:0] m_cnt;
  logic [31:0] gold [0:1023];
  logic        last_gi, last_gd;

  logic [31:0] env_mem [0:1023];

  tb_ram_arbiter #(.RAM_ADDR_WIDTH(AW), .RR_RESET_PRIO(RST_PRIO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(ireq), .instr_gnt_o(igc), .instr_addr_i(iaddr),
    .instr_rvalid_o(irv), .instr_rdata_o(ird), .instr_err_o(ierr),
    .data_req_i(dreq), .data_gnt_o(dgc), .data_addr_i(daddr), .data_we_i(dwe),
    .data_be_i(dbe), .data_wdata_i(dwdata),
    .data_rvalid_o(drv), .data_rdata_o(drd), .data_err_o(derr),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .conflict_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= env_mem[ram_addr[11:2]];
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) env_mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs applied; checks and advances the model.
  task automatic eval();
    logic        eg_i, eg_d, ir, wr;
    logic [31:0] a;
    #1;
    if (!rst_n) begin
      check("rst_gnt", {30'd0, igc, dgc}, 32'd0);
      check("rst_ram", {30'd0, ram_en, ram_we}, 32'd0);
      check("rst_rsp", {28'd0, irv, drv, ierr, derr}, 32'd0);
      check("rst_cnt", cnt, 32'd0);
      m_prio = RST_PRIO; m_pv = 1'b0; m_cnt = 32'd0;
      last_gi = 1'b0; last_gd = 1'b0;
      return;
    end
    eg_i = ireq && (!dreq || m_prio == 1'b0);
    eg_d = dreq && (!ireq || m_prio == 1'b1);
    a    = eg_d ? daddr : iaddr;
    ir   = (a >> AW) == 32'd0;
    wr   = eg_d && dwe;
    check("gnt", {30'd0, igc, dgc}, {30'd0, eg_i, eg_d});
    if ((eg_i || eg_d) && ir) begin
      check("ram_en", {31'd0, ram_en}, 32'd1);
      check("ram_addr", {{(32-AW){1'b0}}, ram_addr}, a & (((32'd1 << AW) - 32'd1) & ~32'd3));
      check("ram_we", {31'd0, ram_we}, {31'd0, wr});
      check("ram_be", {28'd0, ram_be}, eg_d ? {28'd0, dbe} : 32'hF);
      if (wr) check("ram_wdata", ram_wdata, dwdata);
    end else begin
      check("ram_idle", {30'd0, ram_en, ram_we}, 32'd0);
    end
    check("irv", {31'd0, irv}, {31'd0, m_pv && !m_pp});
    check("drv", {31'd0, drv}, {31'd0, m_pv && m_pp});
    check("ird", ird, (m_pv && !m_pp) ? m_prd : 32'd0);
    check("drd", drd, (m_pv && m_pp) ? m_prd : 32'd0);
    check("ierr", {31'd0, ierr}, {31'd0, m_pv && !m_pp && m_perr});
    check("derr", {31'd0, derr}, {31'd0, m_pv && m_pp && m_perr});
    check("cnt", cnt, m_cnt);
    if (ireq && dreq && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    m_pv   = eg_i || eg_d;
    m_pp   = eg_d;
    m_perr = !ir;
    m_prd  = (ir && !wr) ? gold[a[11:2]] : 32'd0;
    if (wr && ir) begin
      for (int b = 0; b < 4; b++) begin
        if (dbe[b]) gold[a[11:2]][8*b +: 8] = dwdata[8*b +: 8];
      end
    end
    if (eg_i || eg_d) m_prio = eg_i;
    last_gi = eg_i; last_gd = eg_d;
  endtask

  task automatic step();
    eval();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) != 0) r = r & 32'h0000_0FFF;
    else r[22] = 1'b1;
    return r;
  endfunction

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 1024; i++) begin
      gold[i] = 32'd0; env_mem[i] = 32'd0;
    end
    ram_rdata = 32'd0;
    rst_n = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dwdata = 32'd0; dbe = 4'd0;
    idle();
    @(negedge clk);
    ireq = 1'b1; dreq = 1'b1;   // requests must be ignored while in reset
    step();
    step();
    idle();
    rst_n = 1'b1;

    // Instruction port alone for five cycles: five grants, no conflicts.
    ireq = 1'b1; iaddr = 32'h0000_0010;
    for (int i = 0; i < 5; i++) step();
    idle();
    step();
    check("solo_cnt", cnt, 32'd0);

    // Continuous dual reads from reset: grants alternate starting with instr.
    do_reset();
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b0;
    iaddr = 32'h0000_0020; daddr = 32'h0000_0024;
    for (int i = 0; i < 6; i++) step();
    idle();
    step();
    check("alt_cnt", cnt, 32'd6);

    // Partial write then read-back of word 0x100.
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h0000_0100; dbe = 4'b0011; dwdata = 32'hDEAD_BEEF;
    step();
    dwe = 1'b0;
    step();
    idle();
    check("wr_rd_data", drd, 32'h0000_BEEF);
    step();

    // Out-of-range instruction fetch.
    ireq = 1'b1; iaddr = 32'h0040_0000;
    #1 check("oor_gnt_en", {30'd0, igc, ram_en}, 32'd2);
    step();
    idle();
    check("oor_resp", {30'd0, irv, ierr}, 32'd3);
    check("oor_rdata", ird, 32'd0);
    step();

    // Randomized traffic; a denied port holds its request unchanged.
    for (int i = 0; i < 400; i++) begin
      if (!(ireq && !last_gi)) begin
        ireq  = ($urandom_range(9) < 6);
        iaddr = rand_addr();
      end
      if (!(dreq && !last_gd)) begin
        dreq   = ($urandom_range(9) < 6);
        daddr  = rand_addr();
        dwe    = $urandom_range(1);
        dbe    = 4'($urandom);
        dwdata = $urandom;
      end
      step();
    end
    idle();
    step();

    // Reset arriving while a data response is pending drops that response.
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h0000_0100;
    eval();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_drop_rv", {31'd0, drv}, 32'd0);
    @(negedge clk);
    ireq = 1'b1; dreq = 1'b1; iaddr = 32'h0000_0008; daddr = 32'h0000_000C;
    eval();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step();
    step();
    ireq = 1'b1; dreq = 1'b1;
    #1 check("post_rst_prio", {30'd0, igc, dgc}, RST_PRIO ? 32'd1 : 32'd2);
    step();
    idle();
    step();

    // Conflict counter saturation.
    force dut.conflict_cnt_q = 32'hFFFF_FFFE;
    #2 release dut.conflict_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    ireq = 1'b1; dreq = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle();
    step();
    check("cnt_sat", cnt, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
